// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, multi-cycle MUL/DIV hold, HALT freeze.
// Latency: all control outputs are combinational from state, cnt and inputs; state/cnt/stall count update each clk edge.
// Backpressure: the controller is the stall source; pc_stall/ifid_stall hold fetch, ex_hold freezes EX during MUL/DIV.
//
// Parameters: MUL_CYCLES, DIV_CYCLES (2..15) = EX occupancy of a multiply / divide.
// Optional feature macro: MULDIV_MULTICYCLE_EN. When undefined, MUL/DIV are single-cycle ALU ops,
//   the MULDIV state is unreachable and ex_hold is tied 0.
// Ports:
//   clk, reset (synchronous, active-low)
//   id_valid/id_op/id_funct/id_rs/id_rt : instruction in ID
//   ex_is_load/ex_rd/ex_branch_taken    : EX stage status
//   pc_stall, ifid_stall, idex_bubble, ex_hold, ifid_flush, idex_flush, halted : pipeline controls
//   stall_cycles : saturating count of cycles with pc_stall=1
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [3:0]  id_op,
    input  logic [3:0]  id_funct,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        ex_is_load,
    input  logic [3:0]  ex_rd,
    input  logic        ex_branch_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        ex_hold,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_cycles
);

`ifdef MULDIV_MULTICYCLE_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // ID decode, all qualified by id_valid
    logic id_is_alu0, id_mul, id_div, id_halt, id_jump;
    logic load_use, md_busy, id_free;

    always_comb begin
        id_is_alu0 = id_valid && (id_op == 4'b0000);
        id_mul     = id_is_alu0 && (id_funct == 4'b0001);
        id_div     = id_is_alu0 && (id_funct == 4'b0010);
        id_halt    = id_is_alu0 && (id_funct == 4'b0000);
        id_jump    = id_valid && (id_op == 4'b1100);
        load_use   = ex_is_load && (ex_rd != 4'd0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt)) && id_valid;
        // EX still busy with a multi-cycle op; the last cycle (cnt==0) releases
        md_busy    = (state_q == ST_MULDIV) && (cnt_q != 4'd0);
        // ID may issue: running, or the final cycle of a MUL/DIV
        id_free    = (state_q == ST_RUN) || ((state_q == ST_MULDIV) && (cnt_q == 4'd0));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_bubble  = 1'b0;
        ex_hold      = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        halted       = 1'b0;
        stall_cycles = stall_cycles_q;

        // Output priority: HALT > branch flush > MULDIV hold > load-use > jump
        if (state_q == ST_HALT) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (md_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
`ifdef MULDIV_MULTICYCLE_EN
            ex_hold    = 1'b1;
`endif
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end

        // Next state. The counter keeps running through a branch cycle so the
        // occupancy of the op already in EX is never shortened.
        if (md_busy) begin
            cnt_d = cnt_q - 4'd1;
        end else if (id_free) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
            // A squashed or stalled ID instruction must not issue
            if (!ex_branch_taken && !load_use) begin
                if (MD_EN && id_mul) begin
                    state_d = ST_MULDIV;
                    cnt_d   = MUL_LOAD;
                end else if (MD_EN && id_div) begin
                    state_d = ST_MULDIV;
                    cnt_d   = DIV_LOAD;
                end else if (id_halt) begin
                    state_d = ST_HALT;
                end
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (pc_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end

        // Reset forces every output low regardless of state or inputs
        if (!reset) begin
            pc_stall     = 1'b0;
            ifid_stall   = 1'b0;
            idex_bubble  = 1'b0;
            ex_hold      = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            halted       = 1'b0;
            stall_cycles = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            cnt_q          <= 4'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_op, id_funct, id_rs, id_rt;
    logic        ex_is_load;
    logic [3:0]  ex_rd;
    logic        ex_branch_taken;
    logic        pc_stall, ifid_stall, idex_bubble, ex_hold;
    logic        ifid_flush, idex_flush, halted;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int base   = 0;

    // Expected control patterns {pc_stall, ifid_stall, idex_bubble, ex_hold, ifid_flush, idex_flush, halted}
    localparam logic [6:0] O_NONE = 7'b000_0000;
    localparam logic [6:0] O_LU   = 7'b111_0000;
    localparam logic [6:0] O_BR   = 7'b000_0110;
    localparam logic [6:0] O_JMP  = 7'b000_0100;
    localparam logic [6:0] O_HOLD = 7'b110_1000;
    localparam logic [6:0] O_HALT = 7'b111_0001;

    logic [6:0] outs;
    assign outs = {pc_stall, ifid_stall, idex_bubble, ex_hold, ifid_flush, idex_flush, halted};

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .ex_hold(ex_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk_o(input string tag, input logic [6:0] exp);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    task automatic chk_sc(input string tag, input logic [15:0] exp);
        checks++;
        assert (stall_cycles === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, stall_cycles, exp);
        end
    endtask

    // Advance one edge; inputs change 1ns after it, checks happen 2ns after it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [3:0] fn,
                          input logic [3:0] rs, input logic [3:0] rt);
        id_valid = v; id_op = op; id_funct = fn; id_rs = rs; id_rt = rt;
    endtask

    task automatic set_ex(input logic ld, input logic [3:0] rd, input logic br);
        ex_is_load = ld; ex_rd = rd; ex_branch_taken = br;
    endtask

    task automatic nop;
        set_id(1'b1, 4'b0001, 4'h0, 4'd1, 4'd2);
        set_ex(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        // Reset held 3 cycles with branch taken and a load-use pattern present
        reset = 1'b0;
        set_id(1'b1, 4'b0000, 4'b0001, 4'd3, 4'd0);
        set_ex(1'b1, 4'd3, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_o("reset_outs", O_NONE);
            chk_sc("reset_sc", 16'd0);
            tick;
        end
        reset = 1'b1;
        nop;
        #1;
        chk_o("post_reset_run", O_NONE);
        chk_sc("post_reset_sc", 16'd0);

`ifdef MULDIV_MULTICYCLE_EN
        // MUL (4 cycles) then back-to-back DIV (8 cycles)
        tick;
        set_id(1'b1, 4'b0000, 4'b0001, 4'd4, 4'd5);
        #1; chk_o("mul_issue", O_NONE);
        tick;
        set_id(1'b1, 4'b0000, 4'b0010, 4'd6, 4'd7);
        for (int i = 0; i < 3; i++) begin
            #1; chk_o("mul_hold", O_HOLD);
            tick;
        end
        #1; chk_o("mul_release_div_issue", O_NONE);
        tick;
        for (int i = 0; i < 7; i++) begin
            #1; chk_o("div_hold", O_HOLD);
            tick;
        end
        nop;
        #1; chk_o("div_release", O_NONE);
        chk_sc("muldiv_sc", 16'd10);
        tick;
        #1; chk_o("after_div_run", O_NONE);
        base = 10;
`else
        // DIV is a single-cycle op: no hold, no stall
        tick;
        set_id(1'b1, 4'b0000, 4'b0010, 4'd6, 4'd7);
        #1; chk_o("div_issue_single", O_NONE);
        tick;
        nop;
        for (int i = 0; i < 4; i++) begin
            #1; chk_o("div_no_hold", O_NONE);
            tick;
        end
        chk_sc("div_no_stall_sc", 16'd0);
        base = 0;
`endif

        // Load-use on rs: one stall cycle
        tick;
        set_id(1'b1, 4'b0001, 4'h0, 4'd3, 4'd9);
        set_ex(1'b1, 4'd3, 1'b0);
        #1; chk_o("loaduse_rs", O_LU);
        tick;
        set_ex(1'b0, 4'd0, 1'b0);
        #1; chk_o("loaduse_released", O_NONE);
        chk_sc("loaduse_sc", 16'(base + 1));

        // Load to r0 never hazards
        set_id(1'b1, 4'b0001, 4'h0, 4'd0, 4'd0);
        set_ex(1'b1, 4'd0, 1'b0);
        #1; chk_o("loaduse_r0", O_NONE);
        tick;
        nop;
        chk_sc("loaduse_r0_sc", 16'(base + 1));

        // Load-use on rt
        set_id(1'b1, 4'b0001, 4'h0, 4'd1, 4'd5);
        set_ex(1'b1, 4'd5, 1'b0);
        #1; chk_o("loaduse_rt", O_LU);
        tick;
        // Invalid ID instruction does not hazard
        id_valid = 1'b0;
        #1; chk_o("loaduse_invalid_id", O_NONE);
        chk_sc("loaduse_rt_sc", 16'(base + 2));
        tick;

        // Branch + load-use + MUL in ID: flush wins, no stall, no issue
        set_id(1'b1, 4'b0000, 4'b0001, 4'd3, 4'd0);
        set_ex(1'b1, 4'd3, 1'b1);
        #1; chk_o("branch_over_loaduse", O_BR);
        tick;
        nop;
        #1; chk_o("branch_no_muldiv", O_NONE);
        chk_sc("branch_sc", 16'(base + 2));

        // Load-use beats jump
        set_id(1'b1, 4'b1100, 4'h0, 4'd7, 4'd0);
        set_ex(1'b1, 4'd7, 1'b0);
        #1; chk_o("loaduse_over_jump", O_LU);
        tick;
        set_ex(1'b0, 4'd0, 1'b0);
        #1; chk_o("jump_flush", O_JMP);
        tick;
        nop;
        #1; chk_o("jump_done", O_NONE);
        chk_sc("jump_sc", 16'(base + 3));

        // HALT: frozen from next cycle, counting stalls, immune to branch
        set_id(1'b1, 4'b0000, 4'b0000, 4'd0, 4'd0);
        #1; chk_o("halt_issue", O_NONE);
        tick;
        nop;
        #1; chk_o("halted", O_HALT);
        chk_sc("halt_sc0", 16'(base + 3));
        set_ex(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) tick;
        #1; chk_o("halted_with_branch", O_HALT);
        chk_sc("halt_sc5", 16'(base + 8));

        // One cycle of reset exits HALT
        reset = 1'b0;
        #1; chk_o("halt_reset_outs", O_NONE);
        chk_sc("halt_reset_sc", 16'd0);
        tick;
        reset = 1'b1;
        nop;
        #1; chk_o("halt_exit", O_NONE);
        chk_sc("halt_exit_sc", 16'd0);

        // Saturation of stall_cycles while halted
        set_id(1'b1, 4'b0000, 4'b0000, 4'd0, 4'd0);
        tick;
        nop;
        repeat (65534) tick;
        chk_sc("sat_fffe", 16'hFFFE);
        tick;
        chk_sc("sat_ffff", 16'hFFFF);
        repeat (3) tick;
        chk_sc("sat_hold", 16'hFFFF);
        chk_o("sat_still_halted", O_HALT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 MUL_CYCLES, 4, number of EX cycles a signed multiply occupies (legal range 2..15).
REQ-002 DIV_CYCLES, 8, number of EX cycles a signed divide occupies (legal range 2..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_op  input  4  opcode in ID.
REQ-007 id_funct  input  4  function field in ID.
REQ-008 id_rs, id_rt  input  4 each  source register numbers in ID.
REQ-009 ex_is_load  input  1  EX holds a load (op 4'b1000).
REQ-010 ex_rd  input  4  destination register of the EX instruction.
REQ-011 ex_branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-012 pc_stall, ifid_stall  output  1 each  hold PC and IF/ID register.
REQ-013 idex_bubble  output  1  load a NOP into ID/EX.
REQ-014 ex_hold  output  1  hold ID/EX and EX state; EX/MEM receives a NOP.
REQ-015 ifid_flush, idex_flush  output  1 each  squash IF/ID and ID/EX.
REQ-016 halted  output  1  pipeline is frozen by halt.
REQ-017 stall_cycles  output  16  count of cycles with pc_stall=1.

Function
REQ-018 Decode: MUL = op 0000 with funct 0001; DIV = op 0000 with funct 0010; HALT = op 0000 with funct 0000; JUMP = op 1100. All decodes are qualified by id_valid.
REQ-019 The FSM has the states RUN, MULDIV and HALT, plus a 4-bit down-counter cnt.
REQ-020 Load-use hazard = ex_is_load & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt) & id_valid. It asserts pc_stall, ifid_stall and idex_bubble for exactly one cycle, combinationally.
REQ-021 Multiply/divide issue: in RUN, if ID holds MUL or DIV and no stall or flush is active, then at the next edge state becomes MULDIV and cnt is loaded with MUL_CYCLES-1 or DIV_CYCLES-1.
REQ-022 In MULDIV with cnt != 0:
- pc_stall, ifid_stall and ex_hold are all 1.
- cnt decrements every cycle.
REQ-023 In MULDIV with cnt == 0:
- no stall is asserted.
- The next state is RUN.
- If ID holds an issuable MUL or DIV, MULDIV is re-entered and cnt is reloaded instead.
- Total EX occupancy is exactly N cycles.
REQ-024 Branch taken asserts ifid_flush and idex_flush in the same cycle.
- It overrides the load-use stall.
- It suppresses any multiply/divide issue from ID.
REQ-025 JUMP in ID (not stalled) asserts ifid_flush for one cycle.
REQ-026 Priority order: reset > HALT state > branch flush > MULDIV hold > load-use > jump.
REQ-027 HALT in ID in RUN (not stalled or flushed) moves the FSM to HALT at the next edge.
- In HALT, pc_stall, ifid_stall, idex_bubble and halted are 1.
- HALT is exited only by reset.
- A HALT arriving during MULDIV waits in ID until the hold releases.
REQ-028 stall_cycles increments on every edge where pc_stall=1, including HALT. It saturates at 16'hFFFF.
REQ-029 Outputs are combinational from state, cnt and inputs. There are no combinational loops.

Reset
REQ-030 On an edge with reset=0: state=RUN, cnt=0, stall_cycles=0.
REQ-031 While reset=0, every output is 0, whatever the other inputs are.
REQ-032 Reset asserted mid-MULDIV or in HALT aborts the operation. The first cycle after release behaves as RUN.

Configuration
REQ-033 Macro MULDIV_MULTICYCLE_EN, when defined: MUL and DIV sequence per REQ-021 to REQ-023.
REQ-034 When MULDIV_MULTICYCLE_EN is not defined:
- MUL and DIV complete in one EX cycle like other ALU ops.
- MULDIV is unreachable and ex_hold is tied 0.
- MUL_CYCLES and DIV_CYCLES are ignored.

Verification
REQ-035 Reset held low 3 cycles with ex_branch_taken=1 -> all outputs 0 and stall_cycles=0; after release, outputs follow RUN rules.
REQ-036 Load to r3 in EX, ID reads rs=3 -> exactly one cycle of pc_stall, ifid_stall, idex_bubble; stall_cycles=1. Same case with ex_rd=0 -> no stall.
REQ-037 MUL issued with MUL_CYCLES=4 -> ex_hold=1 for 3 cycles, then 0; a back-to-back DIV -> 7 more hold cycles; stall_cycles=10.
REQ-038 Load-use hazard and ex_branch_taken in the same cycle -> both flushes=1, pc_stall=0, no MULDIV entry.
REQ-039 HALT in ID -> halted=1 from the next cycle indefinitely, stall_cycles counting; reset low one cycle -> halted=0. stall_cycles held at FFFF saturates.
REQ-040 Build without MULDIV_MULTICYCLE_EN, issue a DIV -> ex_hold never asserts and no stall occurs.
